// File: rtl/ecc_point_check_if.sv
// ecc_point_check_if: job strobe/operands in, qualified job or rejection out
interface ecc_point_check_if #(parameter int W = 256);
  logic         in_valid;
  logic [W-1:0] Px, Py, k;
  logic         busy, out_valid, err_valid;
  logic [W-1:0] Px_o, Py_o, k_o;
  logic [2:0]   err_code;
  logic [7:0]   drop_cnt;
  modport master (output in_valid, Px, Py, k,
                  input busy, out_valid, Px_o, Py_o, k_o, err_valid, err_code, drop_cnt);
  modport slave  (input in_valid, Px, Py, k,
                  output busy, out_valid, Px_o, Py_o, k_o, err_valid, err_code, drop_cnt);
endinterface

// File: rtl/ecc_point_check.sv
// ecc_point_check: range and on-curve qualification of (Px,Py,k) ahead of the dP core; POINT_CHECK_KRANGE_EN also rejects k>=N
module ecc_point_check #(
  parameter int W = 256,
  parameter logic [W-1:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F,
  parameter logic [W-1:0] A = W'(0),
  parameter logic [W-1:0] B = W'(7),
  parameter logic [W-1:0] N = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141
) (
  input logic clk,
  input logic rst,
  ecc_point_check_if.slave bus
);
`ifdef POINT_CHECK_KRANGE_EN
  localparam bit KR = 1'b1;
`else
  localparam bit KR = 1'b0;
`endif
  typedef enum logic [3:0] {IDLE, RANGE, MUL_Y2, MUL_X2, ADD_A, MUL_X3, ADD_B, CMP, DONE} state_t;
  state_t       r_state;
  logic [W-1:0] r_px, r_py, r_k, r_acc, r_mpl, r_y2, r_px_o, r_py_o, r_k_o;
  logic [7:0]   r_cnt, r_drop;
  logic [2:0]   r_err_code;
  logic         r_busy, r_out_valid, r_err_valid;
  logic [W:0]   w_dbl, w_sum, w_asum;
  logic [W-1:0] w_mcand, w_dbl_r, w_mul, w_add;
  logic         w_e0, w_e1;
  // One interleaved multiply step (double, then add multiplicand on a 1 bit) plus the shared modular adder
  always_comb begin
    w_mcand = (r_state == MUL_Y2) ? r_py : r_px;
    w_dbl   = {r_acc, 1'b0};
    w_dbl_r = (w_dbl >= {1'b0, P}) ? W'(w_dbl - {1'b0, P}) : w_dbl[W-1:0];
    w_sum   = {1'b0, w_dbl_r} + {1'b0, w_mcand};
    w_mul   = !r_mpl[W-1] ? w_dbl_r : (w_sum >= {1'b0, P}) ? W'(w_sum - {1'b0, P}) : w_sum[W-1:0];
    w_asum  = {1'b0, r_acc} + {1'b0, (r_state == ADD_A) ? A : B};
    w_add   = (w_asum >= {1'b0, P}) ? W'(w_asum - {1'b0, P}) : w_asum[W-1:0];
    w_e0    = (r_px >= P) || (r_py >= P);
    w_e1    = (r_k == '0) || (KR && (r_k >= N));
  end
  // Job sequencer: capture, range check, y^2 / x^2 / (x^2+A)*x, +B, compare, one-cycle result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_code  <= '0;
      r_px_o      <= '0;
      r_py_o      <= '0;
      r_k_o       <= '0;
      r_drop      <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_mpl       <= '0;
      r_y2        <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_err_valid <= 1'b0;
      if (bus.in_valid && r_state != IDLE && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_px    <= bus.Px;
          r_py    <= bus.Py;
          r_k     <= bus.k;
          r_busy  <= 1'b1;
          r_state <= RANGE;
        end
        RANGE: begin
          r_acc <= '0;
          r_mpl <= r_py;
          r_cnt <= '0;
          if (w_e0 || w_e1) begin
            r_err_valid <= 1'b1;
            r_err_code  <= {1'b0, w_e1, w_e0};
            r_state     <= DONE;
          end else r_state <= MUL_Y2;
        end
        MUL_Y2, MUL_X2, MUL_X3: begin
          r_acc <= w_mul;
          r_mpl <= r_mpl << 1;
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'hFF) r_state <= (r_state == MUL_Y2) ? MUL_X2 : (r_state == MUL_X2) ? ADD_A : ADD_B;
          if (r_cnt == 8'hFF && r_state == MUL_Y2) begin
            r_y2  <= w_mul;
            r_acc <= '0;
            r_mpl <= r_px;
          end
        end
        ADD_A: begin
          r_acc   <= '0;
          r_mpl   <= w_add;
          r_state <= MUL_X3;
        end
        ADD_B: begin
          r_acc   <= w_add;
          r_state <= CMP;
        end
        CMP: begin
          r_state <= DONE;
          if (r_acc == r_y2) begin
            r_out_valid <= 1'b1;
            r_err_code  <= '0;
            r_px_o      <= r_px;
            r_py_o      <= r_py;
            r_k_o       <= r_k;
          end else begin
            r_err_valid <= 1'b1;
            r_err_code  <= 3'b100;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.err_valid = r_err_valid;
  assign bus.err_code  = r_err_code;
  assign bus.Px_o      = r_px_o;
  assign bus.Py_o      = r_py_o;
  assign bus.k_o       = r_k_o;
  assign bus.drop_cnt  = r_drop;
endmodule

// File: tb/tb_ecc_point_check.sv
// tb_ecc_point_check: random and directed jobs scored against a big-integer curve model
module tb_ecc_point_check;
  localparam int W = 256;
  localparam logic [W-1:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [W-1:0] N   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
  localparam logic [W-1:0] A   = 256'd0;
  localparam logic [W-1:0] B   = 256'd7;
  localparam logic [W-1:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [W-1:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam logic [W-1:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam logic [W-1:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
`ifdef POINT_CHECK_KRANGE_EN
  localparam bit KR = 1'b1;
`else
  localparam bit KR = 1'b0;
`endif
  typedef struct {
    bit           pass;
    logic [2:0]   code;
    logic [W-1:0] px, py, k;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   exp_drop = 0;
  logic [W-1:0] last_px = '0, last_py = '0, last_k = '0;
  exp_t sb[$];

  ecc_point_check_if #(.W(W)) bus ();
  ecc_point_check #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] t;
    t = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, P};
    return t[W-1:0];
  endfunction

  function automatic bit on_curve(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W+1:0] rhs;
    rhs = ({2'b0, mulmod(mulmod(x, x), x)} + {2'b0, mulmod(A, x)} + {2'b0, B}) % {2'b0, P};
    return mulmod(y, y) == rhs[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic run_job(input logic [W-1:0] px, input logic [W-1:0] py, input logic [W-1:0] kk,
                         input int gap, input int ndrop, input int rst_at);
    exp_t e;
    bit e0, e1, ok, done;
    int left;
    e0 = (px >= P) || (py >= P);
    e1 = (kk == '0) || (KR && kk >= N);
    ok = !e0 && !e1 && on_curve(px, py);
    if (ok) begin
      last_px = px;
      last_py = py;
      last_k  = kk;
    end
    e.pass = ok;
    e.code = ok ? 3'b000 : (e0 || e1) ? {1'b0, e1, e0} : 3'b100;
    e.px   = last_px;
    e.py   = last_py;
    e.k    = last_k;
    e.cyc  = cyc + 1 + ((e0 || e1) ? 1 : 772);
    sb.push_back(e);
    bus.Px = px;
    bus.Py = py;
    bus.k  = kk;
    bus.in_valid = 1'b1;
    left = ndrop;
    done = 1'b0;
    for (int i = 1; i <= 2000 && !done; i++) begin
      @(negedge clk);
      if (i == 1) chk("busy_after_capture", W'(bus.busy), 1);
      bus.in_valid = 1'b0;
      if (rst_at != 0 && i == rst_at) rst = 1'b1;
      if (rst_at != 0 && i == rst_at + 1) begin
        rst = 1'b0;
        sb.delete();
        last_px = '0;
        last_py = '0;
        last_k  = '0;
        exp_drop = 0;
        chk("rst_busy", W'(bus.busy), 0);
        chk("rst_out_valid", W'(bus.out_valid), 0);
        chk("rst_err_valid", W'(bus.err_valid), 0);
        chk("rst_err_code", W'(bus.err_code), 0);
        chk("rst_Px_o", bus.Px_o, 0);
        chk("rst_Py_o", bus.Py_o, 0);
        chk("rst_k_o", bus.k_o, 0);
        chk("rst_drop_cnt", W'(bus.drop_cnt), 0);
      end
      if (rst_at != 0 && i == rst_at + 800) done = 1'b1;
      if (gap != 0 && left > 0 && i % gap == 0) begin
        bus.in_valid = 1'b1;
        bus.Px = rand256();
        bus.Py = rand256();
        bus.k  = rand256();
        left--;
        if (exp_drop < 255) exp_drop++;
      end
      if (rst_at == 0 && i > 1 && !bus.busy) done = 1'b1;
    end
    bus.in_valid = 1'b0;
    chk("job_completed", W'(done), 1);
    chk("drop_cnt", W'(bus.drop_cnt), W'(exp_drop));
  endtask

  // Scoreboard monitor: every result pulse must match the oldest expected job
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && (bus.out_valid || bus.err_valid)) begin
      chk("pulse_expected", W'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("result_cycle", W'(cyc), W'(e.cyc));
        chk("out_valid", W'(bus.out_valid), W'(e.pass));
        chk("err_valid", W'(bus.err_valid), W'(!e.pass));
        if (!e.pass) chk("err_code", W'(bus.err_code), W'(e.code));
        chk("Px_o", bus.Px_o, e.px);
        chk("Py_o", bus.Py_o, e.py);
        chk("k_o", bus.k_o, e.k);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x, y, kk;
    bus.in_valid = 1'b0;
    bus.Px = '0;
    bus.Py = '0;
    bus.k  = '0;
    repeat (3) @(negedge clk);
    chk("init_busy", W'(bus.busy), 0);
    chk("init_out_valid", W'(bus.out_valid), 0);
    chk("init_err_valid", W'(bus.err_valid), 0);
    chk("init_drop_cnt", W'(bus.drop_cnt), 0);
    chk("init_Px_o", bus.Px_o, 0);
    rst = 1'b0;
    @(negedge clk);
    run_job(GX, GY, 256'd1, 0, 0, 0);
    run_job(GX, GY + 256'd1, 256'd5, 0, 0, 0);
    run_job(P, GY, 256'd0, 0, 0, 0);
    run_job(GX, GY, 256'd0, 0, 0, 0);
    run_job(GX, GY, N, 0, 0, 0);
    run_job(GX, GY, 256'd7, 10, 3, 0);
    run_job(GX, P - GY, 256'd9, 2, 260, 0);
    run_job(G2X, G2Y, 256'd3, 0, 0, 399);
    for (int j = 0; j < 20; j++) begin
      case ($urandom_range(0, 7))
        0: begin x = GX; y = GY; end
        1: begin x = GX; y = P - GY; end
        2: begin x = G2X; y = G2Y; end
        3: begin x = G2X; y = P - G2Y; end
        4: begin x = rand256() % P; y = rand256() % P; end
        5: begin x = P + W'($urandom_range(0, 100)); y = GY; end
        6: begin x = GX; y = P + W'($urandom_range(0, 100)); end
        default: begin x = rand256(); y = rand256(); end
      endcase
      case ($urandom_range(0, 5))
        0: kk = '0;
        1: kk = N;
        2: kk = N + W'($urandom_range(1, 1000));
        3: kk = 256'd1;
        default: kk = rand256();
      endcase
      run_job(x, y, kk, 0, 0, 0);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", W'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ecc_point_check.md
Name: ecc_point_check

Overview:
- Input qualification stage that sits directly upstream of the scalar-multiply (dP) core.
- Accepts a candidate base point (Px, Py) and scalar k, range-checks all operands, and verifies Py^2 = Px^3 + A*Px + B (mod P) using a bit-serial interleaved modular multiplier.
- Valid jobs are forwarded to the dP core as a single-cycle in_valid pulse with stable operands.
- Invalid jobs are rejected with an error code, so the dP core never spends ~100k cycles on garbage.

Parameters:
- W, 256, operand width in bits
- P, FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F, field prime (secp256k1)
- A, 0, curve coefficient a
- B, 7, curve coefficient b
- N, FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141, group order

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  one-cycle job strobe; Px/Py/k valid only in that cycle
- Px  in  W  candidate x
- Py  in  W  candidate y
- k  in  W  scalar
- busy  out  1  high from the sampling edge until the return to IDLE
- out_valid  out  1  one-cycle pulse; drives dP in_valid
- Px_o  out  W  forwarded x; held until the next job
- Py_o  out  W  forwarded y; held until the next job
- k_o  out  W  forwarded k; held until the next job
- err_valid  out  1  one-cycle pulse on rejection
- err_code  out  3  bit0 coordinate >= P, bit1 bad scalar, bit2 not on curve
- drop_cnt  out  8  count of in_valid pulses ignored while busy; saturates at 255

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: rst high at a rising edge forces state IDLE and clears busy, out_valid, err_valid, err_code, Px_o, Py_o, k_o, drop_cnt and all datapath registers to 0. This holds mid-job as well; the aborted job produces no output.
- Capture: in IDLE, in_valid=1 at a rising edge (edge 0) latches Px, Py, k and moves to RANGE; busy=1.
- Busy inputs: in_valid while busy is ignored and increments drop_cnt, which holds at 255.
- States and durations:
  - IDLE -> RANGE on capture.
  - RANGE, 1 cycle: e0 = (Px>=P)|(Py>=P); e1 = (k==0). Any error -> DONE with err_code={0,e1,e0}, so err_valid is high from edge 1. Otherwise -> MUL_Y2.
  - MUL_Y2, 256 cycles: y2 = Py*Py mod P.
  - MUL_X2, 256 cycles: x2 = Px*Px mod P.
  - ADD_A, 1 cycle: t = x2+A mod P.
  - MUL_X3, 256 cycles: r = t*Px mod P.
  - ADD_B, 1 cycle: r = r+B mod P.
  - CMP, 1 cycle: r==y2 -> DONE(pass), else DONE(err_code=3'b100).
  - DONE, 1 cycle: outputs are registered on DONE entry; exactly one of out_valid / err_valid is high for that single cycle, then -> IDLE and busy=0.
- Latency: pass or curve failure, outputs are high from edge 772 after the sampling edge. A new in_valid is accepted in the cycle after DONE.
- Multiplier: MSB-first interleaved, one bit per cycle.
  - acc = 2*acc mod P (conditional subtract).
  - If the multiplier bit is 1: acc = acc + multiplicand mod P (conditional subtract).
  - Intermediates are W+1 bits and the result is always < P.
  - Modular add uses the same W+1 bit add followed by a conditional subtract of P.
- Forwarding: Px_o/Py_o/k_o update only on a pass; on an error they keep their previous values.
- A pass is a single pulse; the downstream core is assumed to sample it in that cycle. There is no backpressure.

Optional Feature:
- Macro POINT_CHECK_KRANGE_EN.
- Defined: RANGE also flags e1 when k>=N, so err_code bit1 means k==0 or k>=N.
- Undefined: only k==0 sets bit1; k>=N is forwarded unchanged.
- Latency is identical in both builds.

Test Plan:
- Valid point: G = (79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798, 483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8), k=1 -> out_valid for exactly 1 cycle at edge 772; Px_o/Py_o/k_o equal the inputs; err_valid stays 0.
- Off-curve point: Gx with Gy+1, k=5 -> err_valid at edge 772, err_code=3'b100, out_valid never rises, Px_o/Py_o/k_o unchanged.
- Range errors:
  - Px=P, Py=Gy, k=0 -> err_valid at edge 1, err_code=3'b011.
  - Px=Gx, Py=Gy, k=0 -> err_code=3'b010 at edge 1.
- Busy and reset:
  - Three in_valid pulses at edges 10/20/30 during a G job -> drop_cnt=3; only one out_valid, at edge 772.
  - rst asserted at edge 400 -> next cycle busy=0 and all outputs 0; no pulse follows.
- Macro: G with k=N -> with POINT_CHECK_KRANGE_EN, err_code=3'b010 at edge 1; without it, out_valid at edge 772 and k_o=N.
